// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the five-stage RISC-V pipeline.
//
// Holds the MEM/WB pipeline register, picks the write-back value
// (ALU result, load data or PC+4), extends sub-word loads and drives the
// register-file write port. Also counts retired instructions.
//
// Configuration macro: RV_WB_LOAD_EXT_EN
//   defined   : LB/LH/LBU/LHU select and extend the addressed byte/half.
//   undefined : load data is the raw memory word for every FUNCT3.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   stall, flush    hold / bubble the MEM/WB register (flush wins)
//   *_MEM           instruction fields arriving from the MEM stage
//   RegWrite_WB     register-file write enable (never for x0)
//   RD_WB           register-file write address (0 when slot empty)
//   ALU_DATA_WB     register-file write data
//   VALID_WB        WB slot holds a real instruction
//   INSTRET_WB      retired-instruction counter
module wb_stage #(
  parameter logic [31:0] RESET_PC_LINK = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        VALID_MEM,
  input  logic        RegWrite_MEM,
  input  logic [1:0]  MemtoReg_MEM,
  input  logic [31:0] ALU_DATA_MEM,
  input  logic [31:0] MEM_DATA_MEM,
  input  logic [31:0] PC_MEM,
  input  logic [4:0]  RD_MEM,
  input  logic [2:0]  FUNCT3_MEM,
  output logic        RegWrite_WB,
  output logic [4:0]  RD_WB,
  output logic [31:0] ALU_DATA_WB,
  output logic        VALID_WB,
  output logic [31:0] INSTRET_WB
);

  logic        valid_q,    valid_d;
  logic        regwrite_q, regwrite_d;
  logic [1:0]  memtoreg_q, memtoreg_d;
  logic [31:0] alu_q,      alu_d;
  logic [31:0] mem_q,      mem_d;
  logic [31:0] pc_q,       pc_d;
  logic [4:0]  rd_q,       rd_d;
  logic [2:0]  funct3_q,   funct3_d;
  logic [31:0] instret_q,  instret_d;

  logic [31:0] load_val;

  // Next-state: flush beats stall; only a real capture retires an instruction.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    alu_d      = alu_q;
    mem_d      = mem_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    instret_d  = instret_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = '0;
    end else if (!stall) begin
      valid_d    = VALID_MEM;
      regwrite_d = RegWrite_MEM;
      memtoreg_d = MemtoReg_MEM;
      alu_d      = ALU_DATA_MEM;
      mem_d      = MEM_DATA_MEM;
      pc_d       = PC_MEM;
      rd_d       = RD_MEM;
      funct3_d   = FUNCT3_MEM;
      instret_d  = instret_q + {31'b0, VALID_MEM};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 2'b00;
      alu_q      <= '0;
      mem_q      <= '0;
      pc_q       <= RESET_PC_LINK;
      rd_q       <= '0;
      funct3_q   <= '0;
      instret_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      alu_q      <= alu_d;
      mem_q      <= mem_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      instret_q  <= instret_d;
    end
  end

`ifdef RV_WB_LOAD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Byte lane from alu[1:0], half lane from alu[1]; alu[0] ignored for halves.
  always_comb begin
    ld_byte  = mem_q[8*alu_q[1:0] +: 8];
    ld_half  = alu_q[1] ? mem_q[31:16] : mem_q[15:0];
    load_val = mem_q;
    case (funct3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'b0, ld_byte};
      3'b101:  load_val = {16'b0, ld_half};
      default: load_val = mem_q;
    endcase
  end
`else
  logic unused_funct3;
  assign unused_funct3 = ^funct3_q;
  assign load_val      = mem_q;
`endif

  always_comb begin
    case (memtoreg_q)
      2'b01:   ALU_DATA_WB = load_val;
      2'b10:   ALU_DATA_WB = pc_q + 32'd4;
      default: ALU_DATA_WB = alu_q;
    endcase
  end

  assign RegWrite_WB = valid_q & regwrite_q & (rd_q != 5'd0);
  assign RD_WB       = valid_q ? rd_q : 5'd0;
  assign VALID_WB    = valid_q;
  assign INSTRET_WB  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        VALID_MEM, RegWrite_MEM;
  logic [1:0]  MemtoReg_MEM;
  logic [31:0] ALU_DATA_MEM, MEM_DATA_MEM, PC_MEM;
  logic [4:0]  RD_MEM;
  logic [2:0]  FUNCT3_MEM;
  logic        RegWrite_WB;
  logic [4:0]  RD_WB;
  logic [31:0] ALU_DATA_WB;
  logic        VALID_WB;
  logic [31:0] INSTRET_WB;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  wb_stage #(.RESET_PC_LINK(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .VALID_MEM(VALID_MEM), .RegWrite_MEM(RegWrite_MEM),
    .MemtoReg_MEM(MemtoReg_MEM), .ALU_DATA_MEM(ALU_DATA_MEM),
    .MEM_DATA_MEM(MEM_DATA_MEM), .PC_MEM(PC_MEM), .RD_MEM(RD_MEM),
    .FUNCT3_MEM(FUNCT3_MEM), .RegWrite_WB(RegWrite_WB), .RD_WB(RD_WB),
    .ALU_DATA_WB(ALU_DATA_WB), .VALID_WB(VALID_WB), .INSTRET_WB(INSTRET_WB)
  );

  // Reference model: the instruction currently sitting in WB, as plain values.
  bit          m_valid, m_rw, m_known;
  int unsigned m_sel, m_alu, m_mem, m_pc, m_rd, m_f3, m_cnt;

  function automatic int unsigned sext(int unsigned v, int unsigned bits);
    int unsigned top = 1 << bits;
    return (v >= top / 2) ? v - top : v;
  endfunction

  function automatic int unsigned model_data();
    int unsigned addr, b, h;
    if (m_sel == 2) return m_pc + 4;
    if (m_sel != 1) return m_alu;
`ifdef RV_WB_LOAD_EXT_EN
    addr = m_alu % 4;
    b = (m_mem >> (8 * addr)) % 256;
    h = (m_mem >> (16 * (addr / 2))) % 65536;
    case (m_f3)
      0: return sext(b, 8);
      1: return sext(h, 16);
      4: return b;
      5: return h;
      default: return m_mem;
    endcase
`else
    addr = 0; b = 0; h = 0;
    return m_mem;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'b0, VALID_WB}, {31'b0, m_valid});
    chk({tag, ".regwrite"}, {31'b0, RegWrite_WB},
        {31'b0, m_valid && m_rw && m_rd != 0});
    chk({tag, ".rd"}, {27'b0, RD_WB}, m_valid ? m_rd : 0);
    chk({tag, ".instret"}, INSTRET_WB, m_cnt);
    if (m_known) chk({tag, ".data"}, ALU_DATA_WB, model_data());
  endtask

  // Apply one clock edge to both DUT and model, then check #1 after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_rw = 0; m_sel = 0; m_alu = 0; m_mem = 0;
      m_pc = 0; m_rd = 0; m_f3 = 0; m_cnt = 0; m_known = 1;
    end else if (flush) begin
      m_valid = 0; m_rw = 0; m_rd = 0; m_known = 0;
    end else if (!stall) begin
      m_valid = VALID_MEM; m_rw = RegWrite_MEM; m_sel = MemtoReg_MEM;
      m_alu = ALU_DATA_MEM; m_mem = MEM_DATA_MEM; m_pc = PC_MEM;
      m_rd = RD_MEM; m_f3 = FUNCT3_MEM; m_known = 1;
      if (VALID_MEM) m_cnt++;
    end
    #1;
    check_all(tag);
  endtask

  task automatic rand_inputs();
    VALID_MEM    = 1'($urandom);
    RegWrite_MEM = 1'($urandom);
    MemtoReg_MEM = 2'($urandom);
    ALU_DATA_MEM = $urandom;
    MEM_DATA_MEM = $urandom;
    PC_MEM       = $urandom;
    RD_MEM       = 5'($urandom);
    FUNCT3_MEM   = 3'($urandom);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc, input logic [4:0] rd,
                       input logic [2:0] f3);
    VALID_MEM = v; RegWrite_MEM = rw; MemtoReg_MEM = sel; ALU_DATA_MEM = alu;
    MEM_DATA_MEM = mem; PC_MEM = pc; RD_MEM = rd; FUNCT3_MEM = f3;
  endtask

  logic [31:0] held;
  logic [31:0] ld_exp [5];
  logic [2:0]  ld_f3  [5];
  logic [1:0]  ld_adr [5];

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_inputs();

    // Reset held with random inputs, stall and flush: outputs stay cleared.
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      stall = 1'($urandom); flush = 1'($urandom);
      step("reset");
      chk("reset.data0", ALU_DATA_WB, 32'h0);
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;

    // ALU op.
    drive(1, 1, 2'b00, 32'h1234_5678, $urandom, $urandom, 5'd5, 3'($urandom));
    step("alu");
    chk("alu.data", ALU_DATA_WB, 32'h1234_5678);
    chk("alu.rd", {27'b0, RD_WB}, 32'd5);
    chk("alu.instret", INSTRET_WB, 32'd1);

    // Loads on MEM_DATA=80F0_7F81: LB@0, LBU@3, LH@2, LHU@0, LW.
    ld_f3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    ld_adr = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b00};
`ifdef RV_WB_LOAD_EXT_EN
    ld_exp = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_7F81, 32'h80F0_7F81};
`else
    ld_exp = '{32'h80F0_7F81, 32'h80F0_7F81, 32'h80F0_7F81, 32'h80F0_7F81, 32'h80F0_7F81};
`endif
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 2'b01, {28'h0001_000, 2'b00, ld_adr[i]}, 32'h80F0_7F81,
            $urandom, 5'd7, ld_f3[i]);
      step("load");
      chk($sformatf("load%0d.data", i), ALU_DATA_WB, ld_exp[i]);
    end

    // JAL link wraps to 0; rd=0 suppresses the write.
    drive(1, 1, 2'b10, $urandom, $urandom, 32'hFFFF_FFFC, 5'd1, 3'b000);
    step("jal");
    chk("jal.data", ALU_DATA_WB, 32'h0);
    chk("jal.regwrite", {31'b0, RegWrite_WB}, 32'd1);
    drive(1, 1, 2'b10, $urandom, $urandom, 32'hFFFF_FFFC, 5'd0, 3'b000);
    step("jal_x0");
    chk("jal_x0.regwrite", {31'b0, RegWrite_WB}, 32'd0);

    // Capture, stall three cycles, then flush together with stall.
    drive(1, 1, 2'b00, 32'hCAFE_F00D, $urandom, $urandom, 5'd9, 3'b000);
    step("pre_stall");
    held = INSTRET_WB;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); VALID_MEM = 1'b1;
      step("stall");
      chk("stall.data", ALU_DATA_WB, 32'hCAFE_F00D);
      chk("stall.instret", INSTRET_WB, held);
    end
    flush = 1'b1;
    step("flush");
    chk("flush.valid", {31'b0, VALID_WB}, 32'd0);
    chk("flush.regwrite", {31'b0, RegWrite_WB}, 32'd0);
    chk("flush.instret", INSTRET_WB, held);
    stall = 1'b0; flush = 1'b0;

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 40) == 0);
      step("rand");
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage RISC-V pipeline: the writer end of the register-file interface that the decode stage reads. It holds the MEM/WB pipeline register, selects the write-back value (ALU result, load data, or PC+4), and extends sub-word loads. It drives the register-file write port (RegWrite_WB, RD_WB, ALU_DATA_WB) and counts retired instructions.

## Interface
- RESET_PC_LINK, 32'h0000_0000, value of the registered PC after reset.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- stall  input  1  hold the MEM/WB register.
- flush  input  1  load a bubble into the MEM/WB register; overrides stall.
- VALID_MEM  input  1  MEM slot holds a real instruction.
- RegWrite_MEM  input  1  instruction writes rd.
- MemtoReg_MEM  input  2  write-back select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- ALU_DATA_MEM  input  32  ALU result; bits [1:0] are the load byte address.
- MEM_DATA_MEM  input  32  raw aligned word from data memory.
- PC_MEM  input  32  instruction PC.
- RD_MEM  input  5  destination register.
- FUNCT3_MEM  input  3  load width and signedness.
- RegWrite_WB  output  1  register-file write enable.
- RD_WB  output  5  register-file write address.
- ALU_DATA_WB  output  32  register-file write data.
- VALID_WB  output  1  WB slot holds a real instruction.
- INSTRET_WB  output  32  retired-instruction counter.

## Operation
- MEM/WB register fields: valid, regwrite, memtoreg, alu, mem, pc, rd, funct3.
- Register update priority, evaluated on each clk edge:
  - reset: valid=0, regwrite=0, memtoreg=00, alu=mem=0, pc=RESET_PC_LINK, rd=0, funct3=0, INSTRET_WB=0.
  - else flush: load a bubble (valid=0, regwrite=0, rd=0); other fields don't care.
  - else stall: hold every field.
  - else capture all MEM inputs.
- RegWrite_WB = valid & regwrite & (rd != 0). A write to x0 is never issued.
- RD_WB = rd when valid, else 0.
- ALU_DATA_WB by memtoreg:
  - 00 or 11: alu.
  - 01: load value.
  - 10: pc + 4, modulo 2^32 (32'hFFFF_FFFC gives 0).
- Load value (with extension enabled):
  - FUNCT3 000 LB: byte alu[1:0], sign-extended.
  - 001 LH: half alu[1], sign-extended; alu[0] ignored.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: half, zero-extended.
  - 011, 110, 111: full word.
- INSTRET_WB increments by 1 on every capture edge with VALID_MEM=1. Flushed, stalled, and reset edges do not increment. Wraps from 32'hFFFF_FFFF to 0.

## Timing
- One-cycle latency: MEM inputs sampled at edge N appear on the WB outputs after edge N, and stay combinational from the register until the next update.
- All outputs are combinational from registered state only; there are no input-to-output combinational paths.
- Reset values: RegWrite_WB=0, RD_WB=0, ALU_DATA_WB=0, VALID_WB=0, INSTRET_WB=0.
- Reset asserted mid-stall or mid-flush: reset wins, and the cleared state appears after that edge.
- Simultaneous stall and flush: flush wins.
- Deasserting stall resumes capture on the next edge. The held instruction is counted only once (at its original capture).
- The register file writes on the same edge that the WB register next updates. Decode-stage bypass is outside this block.

## Configuration
- Macro: RV_WB_LOAD_EXT_EN.
- Defined: sub-word load selection and extension as specified under Operation.
- Undefined: the load value is MEM_DATA_MEM passed through unchanged for every FUNCT3. FUNCT3 and ALU_DATA[1:0] do not affect write-back data. All other behaviour is identical.

## Test plan
- Reset, then drive random inputs with reset held -> all outputs 0 every cycle. Release reset -> the first capture appears one cycle later.
- ALU op: VALID=1, RegWrite=1, MemtoReg=00, ALU=32'h1234_5678, RD=5 -> next cycle RegWrite_WB=1, RD_WB=5, ALU_DATA_WB=32'h1234_5678, INSTRET_WB=1.
- Loads (extension enabled), MEM_DATA=32'h80F0_7F81:
  - LB addr 00 -> 32'hFFFF_FF81.
  - LBU addr 11 -> 32'h0000_0080.
  - LH addr 10 -> 32'hFFFF_80F0.
  - LHU addr 00 -> 32'h0000_7F81.
  - LW -> 32'h80F0_7F81.
- Macro undefined, same stimulus -> all five loads produce 32'h80F0_7F81.
- JAL: MemtoReg=10, PC=32'hFFFF_FFFC, RD=1 -> ALU_DATA_WB=0. Same with RD=0 -> RegWrite_WB=0.
- Three cycles of stall, then flush asserted together with stall -> outputs held for the stall cycles, then a bubble (RegWrite_WB=0, VALID_WB=0). INSTRET_WB unchanged across the stall and flush cycles.
